dbg_snapshot_tx: RTL and testbench

Debug-monitor reader for the CDECV core. On a capture request, it scans all eight debug-visible datapath values (PC, A, B, C, T, R, FLG, Xbus) through the datapath's two debug read ports and latches them into a snapshot buffer. It then streams the snapshot as a byte frame over a valid/ready handshake to the board monitor link (UART transmitter or host FIFO). It is the active end of the datapath debug interface: it drives the debug addresses and consumes the debug data.

---
 rtl/dbg_monitor_pkg.sv | 27 ++
 rtl/dbg_snapshot_tx.sv | 157 +++++++++++++++
 tb/tb_dbg_snapshot_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dbg_monitor_pkg.sv
// Shared definitions for the CDECV debug monitor: FSM states, debug addresses, frame constants.
// Frame length depends on DBG_SNAPSHOT_CHECKSUM_EN (see dbg_snapshot_tx).
package dbg_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSend
    } dbg_state_e;

    typedef logic [2:0] dbg_addr_t;

    localparam dbg_addr_t DBG_PC   = 3'd0;
    localparam dbg_addr_t DBG_A    = 3'd1;
    localparam dbg_addr_t DBG_B    = 3'd2;
    localparam dbg_addr_t DBG_C    = 3'd3;
    localparam dbg_addr_t DBG_T    = 3'd4;
    localparam dbg_addr_t DBG_R    = 3'd5;
    localparam dbg_addr_t DBG_FLG  = 3'd6;
    localparam dbg_addr_t DBG_XBUS = 3'd7;

    localparam logic [7:0] DBG_HEADER_DEFAULT = 8'hA5;

    localparam int unsigned FRAME_LEN_BASE = 9;
    localparam int unsigned FRAME_LEN_CSUM = 10;

endpackage

// File: rtl/dbg_snapshot_tx.sv
// Scans the eight debug-visible datapath values into a snapshot and streams them as a byte frame.
// Define DBG_SNAPSHOT_CHECKSUM_EN to append an XOR checksum byte over the eight data bytes.
module dbg_snapshot_tx
    import dbg_monitor_pkg::*;
#(
    parameter logic [7:0] HEADER = DBG_HEADER_DEFAULT
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      capture,
    output dbg_addr_t dbg_addr0,
    input  logic [7:0] dbg_data0,
    output dbg_addr_t dbg_addr1,
    input  logic [7:0] dbg_data1,
    output logic      freeze,
    output logic [7:0] tx_data,
    output logic      tx_valid,
    input  logic      tx_ready,
    output logic      busy,
    output logic      done
);

`ifdef DBG_SNAPSHOT_CHECKSUM_EN
    localparam int unsigned FrameLen = FRAME_LEN_CSUM;
`else
    localparam int unsigned FrameLen = FRAME_LEN_BASE;
`endif
    localparam logic [3:0] LastIdx = 4'(FrameLen - 1);

    dbg_state_e state_q, state_d;
    logic [1:0] scan_idx_q, scan_idx_d;
    logic [3:0] byte_idx_q, byte_idx_d;
    logic [7:0] snap_q [8];
    logic [7:0] snap_d [8];
    dbg_addr_t  addr0_q, addr0_d, addr1_q, addr1_d;
    logic       freeze_q, freeze_d, busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic [7:0] data_q, data_d;
    logic [3:0] nxt_idx;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        freeze_d   = freeze_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        data_d     = data_q;
        done_d     = 1'b0;
        nxt_idx    = byte_idx_q + 4'd1;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d    = StScan;
                    scan_idx_d = 2'd0;
                    addr0_d    = DBG_PC;
                    addr1_d    = DBG_A;
                    freeze_d   = 1'b1;
                    busy_d     = 1'b1;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            StScan: begin
                snap_d[{scan_idx_q, 1'b0}] = dbg_data0;
                snap_d[{scan_idx_q, 1'b1}] = dbg_data1;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
                csum_d = csum_q ^ dbg_data0 ^ dbg_data1;
`endif
                if (scan_idx_q == 2'd3) begin
                    state_d    = StSend;
                    byte_idx_d = 4'd0;
                    addr0_d    = DBG_PC;
                    addr1_d    = DBG_PC;
                    freeze_d   = 1'b0;
                    valid_d    = 1'b1;
                    data_d     = HEADER;
                end else begin
                    scan_idx_d = scan_idx_q + 2'd1;
                    addr0_d    = {scan_idx_d, 1'b0};
                    addr1_d    = {scan_idx_d, 1'b1};
                end
            end
            StSend: begin
                if (valid_q && tx_ready) begin
                    if (byte_idx_q == LastIdx) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        data_d  = 8'h00;
                        done_d  = 1'b1;
                    end else begin
                        byte_idx_d = nxt_idx;
                        // Byte 0 is the header, so frame byte n carries snapshot entry n-1.
                        data_d     = snap_q[3'(nxt_idx - 4'd1)];
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
                        if (nxt_idx == LastIdx) data_d = csum_q;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            scan_idx_q <= 2'd0;
            byte_idx_q <= 4'd0;
            for (int i = 0; i < 8; i++) snap_q[i] <= 8'h00;
            addr0_q    <= DBG_PC;
            addr1_q    <= DBG_PC;
            freeze_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            freeze_q   <= freeze_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            done_q     <= done_d;
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign dbg_addr0 = addr0_q;
    assign dbg_addr1 = addr1_q;
    assign freeze    = freeze_q;
    assign busy      = busy_q;
    assign tx_valid  = valid_q;
    assign tx_data   = data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dbg_snapshot_tx.sv
// Directed bench for dbg_snapshot_tx; honours DBG_SNAPSHOT_CHECKSUM_EN for the expected frame.
module tb_dbg_snapshot_tx;

`ifdef DBG_SNAPSHOT_CHECKSUM_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 9;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       capture = 1'b0;
    logic       tx_ready = 1'b1;
    logic [2:0] dbg_addr0, dbg_addr1;
    logic [7:0] dbg_data0, dbg_data1, tx_data;
    logic       freeze, tx_valid, busy, done;

    logic [7:0] dp [8];
    logic [7:0] expf [10];
    logic [7:0] got [$];
    logic [3:0] rdy_pat = 4'b1001;
    int         errors = 0, checks = 0;
    int         nfreeze, ndone, addr_err, stab_err;
    bit         timed_out;

    assign dbg_data0 = dp[dbg_addr0];
    assign dbg_data1 = dp[dbg_addr1];

    always #5 clock = ~clock;

    dbg_snapshot_tx dut (
        .clock    (clock),
        .reset    (reset),
        .capture  (capture),
        .dbg_addr0(dbg_addr0),
        .dbg_data0(dbg_data0),
        .dbg_addr1(dbg_addr1),
        .dbg_data1(dbg_data1),
        .freeze   (freeze),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic set_dp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) dp[i] = v[8*(7-i) +: 8];
    endtask

    // Expected frame from the bench's own datapath values (chg: values rewritten per scan cycle).
    task automatic build_exp(input bit chg);
        logic [7:0] x;
        x = 8'h00;
        expf[0] = 8'hA5;
        for (int j = 0; j < 8; j++) begin
            expf[j+1] = chg ? 8'(8'h40 + 16 * (j / 2) + j) : dp[j];
            x = x ^ expf[j+1];
        end
        expf[9] = x;
    endtask

    task automatic start_capture();
        @(negedge clock);
        capture = 1'b1;
        @(negedge clock);
        capture = 1'b0;
    endtask

    // Runs from a negedge in scan cycle 0 until done (or stop_after accepted bytes).
    task automatic collect(input bit stall, input bit chg, input int stop_after);
        bit pv, pa;
        logic [7:0] pd;
        got.delete();
        nfreeze = 0; ndone = 0; addr_err = 0; stab_err = 0; timed_out = 1;
        pv = 0; pa = 0; pd = 8'h00;
        for (int cyc = 0; cyc < 80; cyc++) begin
            tx_ready = stall ? rdy_pat[cyc % 4] : 1'b1;
            if (chg && freeze)
                for (int i = 0; i < 8; i++) dp[i] = 8'(8'h40 + nfreeze * 16 + i);
            #1;
            if (freeze) begin
                if (dbg_addr0 !== 3'(2 * nfreeze) || dbg_addr1 !== 3'(2 * nfreeze + 1))
                    addr_err++;
                nfreeze++;
            end else if (dbg_addr0 !== 3'd0 || dbg_addr1 !== 3'd0) begin
                addr_err++;
            end
            if (tx_valid && pv && !pa && tx_data !== pd) stab_err++;
            pa = tx_valid && tx_ready;
            pv = tx_valid;
            pd = tx_data;
            if (pa) got.push_back(tx_data);
            if (done) ndone++;
            if (done || (stop_after != 0 && got.size() == stop_after)) begin
                timed_out = 0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (dbg_addr0 !== 3'd0) begin errors++; $display("FAIL reset_addr0 got=%0d exp=0", dbg_addr0); end
        checks++; if (dbg_addr1 !== 3'd0) begin errors++; $display("FAIL reset_addr1 got=%0d exp=0", dbg_addr1); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        set_dp(64'h10_01_02_03_04_05_0A_FF);
        build_exp(1'b0);
        start_capture();
        collect(1'b0, 1'b0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++; if (nfreeze != 4) begin errors++; $display("FAIL basic_freeze_cycles got=%0d exp=4", nfreeze); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL basic_addr got=%0d_bad exp=0_bad", addr_err); end
        checks++; if (got.size() != FLEN) begin errors++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expf[i]) begin errors++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got[i], expf[i]); end
        end
`ifdef DBG_SNAPSHOT_CHECKSUM_EN
        checks++; if (expf[9] !== 8'hE4) begin errors++; $display("FAIL basic_csum_model got=%h exp=e4", expf[9]); end
`endif
        @(negedge clock); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle got=busy%b_done%b exp=0_0", busy, done); end
    endtask

    task automatic test_stall();
        set_dp(64'h11_22_33_44_55_66_77_88);
        build_exp(1'b0);
        start_capture();
        collect(1'b1, 1'b0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got=no_done exp=done"); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable got=%0d_changes exp=0", stab_err); end
        checks++; if (got.size() != FLEN) begin errors++; $display("FAIL stall_len got=%0d exp=%0d", got.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expf[i]) begin errors++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got[i], expf[i]); end
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_capture_held();
        set_dp(64'hC0_C1_C2_C3_C4_C5_C6_C7);
        @(negedge clock);
        capture = 1'b1;
        @(negedge clock);
        collect(1'b0, 1'b0, 0);
        checks++; if (ndone != 1 || nfreeze != 4) begin errors++; $display("FAIL held_one_frame got=done%0d_frz%0d exp=1_4", ndone, nfreeze); end
        checks++; if (got.size() != FLEN) begin errors++; $display("FAIL held_len got=%0d exp=%0d", got.size(), FLEN); end
        @(negedge clock); #1;
        checks++; if (freeze !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL held_recapture got=frz%b_busy%b exp=1_1", freeze, busy); end
        capture = 1'b0;
        @(negedge clock);
        collect(1'b0, 1'b0, 0);
        checks++; if (ndone != 1 || nfreeze != 3) begin errors++; $display("FAIL held_second got=done%0d_frz%0d exp=1_3", ndone, nfreeze); end
    endtask

    task automatic test_reset_mid_send();
        set_dp(64'h01_23_45_67_89_AB_CD_EF);
        start_capture();
        collect(1'b0, 1'b0, 4);
        checks++; if (timed_out) begin errors++; $display("FAIL rst_reach4 got=timeout exp=4_bytes"); end
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got=v%b_b%b exp=0_0", tx_valid, busy); end
        @(negedge clock); #1;
        checks++; if (done !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rst_no_done got=d%b_v%b exp=0_0", done, tx_valid); end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle got=d%b_b%b exp=0_0", done, busy); end
        end
        build_exp(1'b0);
        start_capture();
        collect(1'b0, 1'b0, 0);
        checks++; if (got.size() != FLEN) begin errors++; $display("FAIL rst_refr_len got=%0d exp=%0d", got.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expf[i]) begin errors++; $display("FAIL rst_refr_byte%0d got=%h exp=%h", i, got[i], expf[i]); end
        end
    endtask

    task automatic test_scan_change();
        set_dp(64'hEE_EE_EE_EE_EE_EE_EE_EE);
        build_exp(1'b1);
        start_capture();
        collect(1'b0, 1'b1, 0);
        checks++; if (got.size() != FLEN) begin errors++; $display("FAIL chg_len got=%0d exp=%0d", got.size(), FLEN); end
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expf[i]) begin errors++; $display("FAIL chg_byte%0d got=%h exp=%h", i, got[i], expf[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dp[i] = 8'h00;
        test_reset();
        test_basic_frame();
        test_stall();
        test_capture_held();
        test_reset_mid_send();
        test_scan_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
